// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// FSM state encoding, forward-select codes and register-index width.
package hazard_stall_ctrl_pkg;

   localparam int REG_W = 5;

   typedef enum logic {
      RUN     = 1'b0,
      MEMWAIT = 1'b1
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_stall_ctrl_fwd_select_unit.sv
// Forward-select decision for one EXE source operand.
// The ID source register is matched against the destinations that will be
// one stage further on the next edge. An EXE-stage ALU result takes
// priority over a MEM-stage result. A load in EXE cannot be forwarded
// from the MEM ALU path. Register $0 never forwards.
module fwd_select_unit
   import hazard_stall_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic [REG_W-1:0] exe_rw,
   input  logic             exe_regwr,
   input  logic             exe_memtoreg,
   input  logic [REG_W-1:0] mem_rw,
   input  logic             mem_regwr,
   output logic [1:0]       sel
);

   // Priority select: EXE ALU result, then MEM/WB data, then register file
   always_comb begin
      sel = FWD_RF;
      if (exe_regwr && (exe_rw != '0) && (exe_rw == src) && !exe_memtoreg)
         sel = FWD_MEM;
      else if (mem_regwr && (mem_rw != '0) && (mem_rw == src))
         sel = FWD_WB;
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central hazard and stall controller for the 5-stage pipeline.
// Priority, highest first: memory wait, branch flush, load-use.
// Stall/flush outputs are Mealy from the registered FSM state; forward
// selects are registered alongside the ID/EXE register.
// Optional macro HAZARD_PERF_CNT_EN adds saturating 32-bit event counters.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
)(
   input  logic             CLK,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] exe_rw,
   input  logic             exe_regwr,
   input  logic             exe_memtoreg,
   input  logic [REG_W-1:0] mem_rw,
   input  logic             mem_regwr,
   input  logic             exe_branch_taken,
   input  logic             mem_access,
   input  logic             mem_ready,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             id_exe_stall,
   output logic             exe_mem_stall,
   output logic             if_id_flush,
   output logic             id_exe_flush,
   output logic             mem_wb_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             err_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]      ld_stall_cnt,
   output logic [31:0]      br_flush_cnt,
   output logic [31:0]      mem_wait_cnt
`endif
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_wait_act;
   logic             timeout_hit;
   logic             load_use;
   logic             br_act;
   logic             lu_act;
   logic [1:0]       next_fwd_a;
   logic [1:0]       next_fwd_b;

   fwd_select_unit u_fwd_rs (
      .src          (id_rs),
      .exe_rw       (exe_rw),
      .exe_regwr    (exe_regwr),
      .exe_memtoreg (exe_memtoreg),
      .mem_rw       (mem_rw),
      .mem_regwr    (mem_regwr),
      .sel          (next_fwd_a)
   );

   fwd_select_unit u_fwd_rt (
      .src          (id_rt),
      .exe_rw       (exe_rw),
      .exe_regwr    (exe_regwr),
      .exe_memtoreg (exe_memtoreg),
      .mem_rw       (mem_rw),
      .mem_regwr    (mem_regwr),
      .sel          (next_fwd_b)
   );

   // Event decode; everything is forced quiet while reset is asserted
   always_comb begin
      load_use     = exe_memtoreg && exe_regwr && (exe_rw != '0) &&
                     ((id_uses_rs && (id_rs == exe_rw)) ||
                      (id_uses_rt && (id_rt == exe_rw)));
      mem_wait_act = reset &&
                     (((state == RUN) && mem_access && !mem_ready) ||
                      ((state == MEMWAIT) && !mem_ready && (wait_cnt < LAST_CNT)));
      timeout_hit  = reset && (state == MEMWAIT) && !mem_ready && (wait_cnt >= LAST_CNT);
      // The ID instruction is wrong-path on a taken branch, so branch wins over load-use
      br_act       = reset && (state == RUN) && !mem_wait_act && exe_branch_taken;
      lu_act       = reset && (state == RUN) && !mem_wait_act && !exe_branch_taken && load_use;
   end

   // Mealy stall/flush outputs
   always_comb begin
      pc_stall      = mem_wait_act || lu_act;
      if_id_stall   = mem_wait_act || lu_act;
      id_exe_stall  = mem_wait_act;
      exe_mem_stall = mem_wait_act;
      mem_wb_bubble = mem_wait_act;
      if_id_flush   = br_act;
      id_exe_flush  = br_act || lu_act;
   end

   // Memory-wait FSM with timeout watchdog and sticky error flag
   always_ff @(posedge CLK) begin
      if (!reset) begin
         state       <= RUN;
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mem_wait_act) begin
                  state    <= MEMWAIT;
                  wait_cnt <= '0;
               end
            end
            MEMWAIT: begin
               if (mem_wait_act)
                  wait_cnt <= wait_cnt + CNT_W'(1);
               else
                  state <= RUN;
               if (timeout_hit)
                  err_timeout <= 1'b1;
            end
            default: state <= RUN;
         endcase
      end
   end

   // ---- ID/EXE boundary: forward selects travel with the ID/EXE register
   always_ff @(posedge CLK) begin
      if (!reset) begin
         fwd_a <= FWD_RF;
         fwd_b <= FWD_RF;
      end else if (!id_exe_stall) begin
         fwd_a <= id_exe_flush ? FWD_RF : next_fwd_a;
         fwd_b <= id_exe_flush ? FWD_RF : next_fwd_b;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating event counters
   always_ff @(posedge CLK) begin
      if (!reset) begin
         ld_stall_cnt <= '0;
         br_flush_cnt <= '0;
         mem_wait_cnt <= '0;
      end else begin
         if (lu_act && (ld_stall_cnt != 32'hFFFF_FFFF))
            ld_stall_cnt <= ld_stall_cnt + 32'd1;
         if (br_act && (br_flush_cnt != 32'hFFFF_FFFF))
            br_flush_cnt <= br_flush_cnt + 32'd1;
         if (mem_wait_act && (mem_wait_cnt != 32'hFFFF_FFFF))
            mem_wait_cnt <= mem_wait_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl, built with MEM_TIMEOUT = 4.
// ctl = {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
//        if_id_flush, id_exe_flush, mem_wb_bubble}
module tb_hazard_stall_ctrl;

   logic       CLK;
   logic       reset;
   logic [4:0] id_rs, id_rt, exe_rw, mem_rw;
   logic       id_uses_rs, id_uses_rt, exe_regwr, exe_memtoreg, mem_regwr;
   logic       exe_branch_taken, mem_access, mem_ready;
   logic       pc_stall, if_id_stall, id_exe_stall, exe_mem_stall;
   logic       if_id_flush, id_exe_flush, mem_wb_bubble, err_timeout;
   logic [1:0] fwd_a, fwd_b;
   logic [6:0] ctl;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [6:0] CTL_NONE = 7'b0000000;
   localparam logic [6:0] CTL_LU   = 7'b1100010;
   localparam logic [6:0] CTL_BR   = 7'b0000110;
   localparam logic [6:0] CTL_MEM  = 7'b1111001;

   hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .CLK              (CLK),
      .reset            (reset),
      .id_rs            (id_rs),
      .id_rt            (id_rt),
      .id_uses_rs       (id_uses_rs),
      .id_uses_rt       (id_uses_rt),
      .exe_rw           (exe_rw),
      .exe_regwr        (exe_regwr),
      .exe_memtoreg     (exe_memtoreg),
      .mem_rw           (mem_rw),
      .mem_regwr        (mem_regwr),
      .exe_branch_taken (exe_branch_taken),
      .mem_access       (mem_access),
      .mem_ready        (mem_ready),
      .pc_stall         (pc_stall),
      .if_id_stall      (if_id_stall),
      .id_exe_stall     (id_exe_stall),
      .exe_mem_stall    (exe_mem_stall),
      .if_id_flush      (if_id_flush),
      .id_exe_flush     (id_exe_flush),
      .mem_wb_bubble    (mem_wb_bubble),
      .fwd_a            (fwd_a),
      .fwd_b            (fwd_b),
      .err_timeout      (err_timeout)
   );

   assign ctl = {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
                 if_id_flush, id_exe_flush, mem_wb_bubble};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      exe_rw = 0; exe_regwr = 0; exe_memtoreg = 0;
      mem_rw = 0; mem_regwr = 0;
      exe_branch_taken = 0; mem_access = 0; mem_ready = 0;
   endtask

   task automatic test_reset();
      reset = 0;
      idle_inputs();
      mem_access = 1;
      exe_branch_taken = 1;
      tick();
      tick();
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL reset_ctl: got %b required %b", ctl, CTL_NONE);
      end
      n_cmp++;
      if ({fwd_a, fwd_b, err_timeout} !== 5'b0) begin
         n_err++; $display("FAIL reset_regs: got %b required 00000", {fwd_a, fwd_b, err_timeout});
      end
      idle_inputs();
      reset = 1;
      tick();
   endtask

   task automatic test_load_use();
      idle_inputs();
      exe_memtoreg = 1; exe_regwr = 1; exe_rw = 5;
      id_rs = 5; id_uses_rs = 1;
      #1;
      n_cmp++;
      if (ctl !== CTL_LU) begin
         n_err++; $display("FAIL load_use_ctl: got %b required %b", ctl, CTL_LU);
      end
      tick();
      // The load has moved to MEM, a bubble sits in EXE
      exe_memtoreg = 0; exe_regwr = 0; exe_rw = 0;
      mem_rw = 5; mem_regwr = 1;
      #1;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL load_use_release: got %b required %b", ctl, CTL_NONE);
      end
      n_cmp++;
      if (fwd_a !== 2'b00) begin
         n_err++; $display("FAIL load_use_bubble_fwd: got %b required 00", fwd_a);
      end
      tick();
      n_cmp++;
      if (fwd_a !== 2'b10) begin
         n_err++; $display("FAIL load_use_fwd_wb: got %b required 10", fwd_a);
      end
      // $0 never triggers load-use
      idle_inputs();
      exe_memtoreg = 1; exe_regwr = 1; exe_rw = 0; id_uses_rs = 1;
      #1;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL load_use_r0: got %b required %b", ctl, CTL_NONE);
      end
      tick();
   endtask

   task automatic test_alu_fwd();
      idle_inputs();
      exe_regwr = 1; exe_rw = 3; id_rt = 3; id_uses_rt = 1;
      #1;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL alu_fwd_ctl: got %b required %b", ctl, CTL_NONE);
      end
      tick();
      n_cmp++;
      if ({fwd_a, fwd_b} !== 4'b0001) begin
         n_err++; $display("FAIL alu_fwd_b: got %b required 0001", {fwd_a, fwd_b});
      end
      exe_rw = 0; id_rt = 0;
      tick();
      n_cmp++;
      if (fwd_b !== 2'b00) begin
         n_err++; $display("FAIL alu_fwd_r0: got %b required 00", fwd_b);
      end
      // EXE result wins over MEM for the same register
      idle_inputs();
      exe_regwr = 1; exe_rw = 7; mem_regwr = 1; mem_rw = 7; id_rs = 7;
      tick();
      n_cmp++;
      if (fwd_a !== 2'b01) begin
         n_err++; $display("FAIL fwd_priority: got %b required 01", fwd_a);
      end
      // A load in EXE is not an ALU source; fall back to MEM
      exe_memtoreg = 1;
      tick();
      n_cmp++;
      if (fwd_a !== 2'b10) begin
         n_err++; $display("FAIL fwd_load_skip: got %b required 10", fwd_a);
      end
   endtask

   task automatic test_branch();
      idle_inputs();
      exe_memtoreg = 1; exe_regwr = 1; exe_rw = 5;
      id_rs = 5; id_uses_rs = 1; id_rt = 9;
      mem_regwr = 1; mem_rw = 9;
      exe_branch_taken = 1;
      #1;
      n_cmp++;
      if (ctl !== CTL_BR) begin
         n_err++; $display("FAIL branch_ctl: got %b required %b", ctl, CTL_BR);
      end
      tick();
      n_cmp++;
      if ({fwd_a, fwd_b} !== 4'b0000) begin
         n_err++; $display("FAIL branch_fwd: got %b required 0000", {fwd_a, fwd_b});
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_mem_wait();
      idle_inputs();
      mem_access = 1; mem_ready = 0;
      exe_regwr = 1; exe_rw = 3; id_rs = 3;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (ctl !== CTL_MEM) begin
            n_err++; $display("FAIL mem_wait_ctl[%0d]: got %b required %b", i, ctl, CTL_MEM);
         end
         tick();
         n_cmp++;
         if (fwd_a !== 2'b00) begin
            n_err++; $display("FAIL mem_wait_fwd_hold[%0d]: got %b required 00", i, fwd_a);
         end
      end
      mem_ready = 1;
      #1;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL mem_ready_ctl: got %b required %b", ctl, CTL_NONE);
      end
      tick();
      n_cmp++;
      if (fwd_a !== 2'b01) begin
         n_err++; $display("FAIL mem_ready_fwd: got %b required 01", fwd_a);
      end
      // Back in RUN: no access means no stall even with mem_ready low
      idle_inputs();
      #1;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL mem_wait_back_run: got %b required %b", ctl, CTL_NONE);
      end
      n_cmp++;
      if (err_timeout !== 1'b0) begin
         n_err++; $display("FAIL mem_wait_err: got %b required 0", err_timeout);
      end
      tick();
   endtask

   task automatic test_timeout();
      idle_inputs();
      mem_access = 1; mem_ready = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (ctl !== CTL_MEM) begin
            n_err++; $display("FAIL timeout_stall[%0d]: got %b required %b", i, ctl, CTL_MEM);
         end
         tick();
      end
      #1;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL timeout_release: got %b required %b", ctl, CTL_NONE);
      end
      tick();
      mem_access = 0;
      n_cmp++;
      if (err_timeout !== 1'b1) begin
         n_err++; $display("FAIL timeout_err_set: got %b required 1", err_timeout);
      end
      tick();
      tick();
      n_cmp++;
      if ({ctl, err_timeout} !== {CTL_NONE, 1'b1}) begin
         n_err++; $display("FAIL timeout_err_sticky: got %b required %b", {ctl, err_timeout}, {CTL_NONE, 1'b1});
      end
   endtask

   task automatic test_reset_mid_wait();
      idle_inputs();
      mem_access = 1; mem_ready = 0;
      exe_regwr = 1; exe_rw = 4; id_rt = 4;
      tick();
      reset = 0;
      #1;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL rst_wait_ctl: got %b required %b", ctl, CTL_NONE);
      end
      tick();
      n_cmp++;
      if ({fwd_a, fwd_b, err_timeout} !== 5'b0) begin
         n_err++; $display("FAIL rst_wait_regs: got %b required 00000", {fwd_a, fwd_b, err_timeout});
      end
      reset = 1;
      idle_inputs();
      #1;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL rst_wait_state_run: got %b required %b", ctl, CTL_NONE);
      end
      tick();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_load_use();
      test_alu_fwd();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central hazard and stall controller for the 5-stage pipeline.
- Generates stall, flush and bubble controls for the PC and for the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
- Generates registered forwarding selects for the EXE operand muxes.
- Sequences multi-cycle data-memory waits through a small FSM with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 16, maximum number of MEMWAIT cycles before forced release (range 2..255).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- CLK  in  1  pipeline clock.
- reset  in  1  synchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- exe_rw  in  5  destination register of the instruction in EXE.
- exe_regwr  in  1  EXE instruction writes a register.
- exe_memtoreg  in  1  EXE instruction is a load.
- mem_rw  in  5  destination register of the instruction in MEM.
- mem_regwr  in  1  MEM instruction writes a register.
- exe_branch_taken  in  1  branch or jump resolved taken in EXE.
- mem_access  in  1  MEM stage is performing a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- id_exe_stall  out  1  hold ID/EXE.
- exe_mem_stall  out  1  hold EXE/MEM.
- if_id_flush  out  1  clear IF/ID.
- id_exe_flush  out  1  clear ID/EXE (bubble).
- mem_wb_bubble  out  1  load NOP into MEM/WB.
- fwd_a  out  2  EXE operand A select: 00 = register file, 01 = MEM ALU result, 10 = WB data.
- fwd_b  out  2  EXE operand B select, same encoding as fwd_a.
- err_timeout  out  1  sticky flag: memory wait timed out.

Behaviour:
- Clocking and reset: one clock, CLK. reset is synchronous and active-low.
- While reset = 0:
  - all control outputs read 0;
  - fwd_a = fwd_b = 00;
  - err_timeout = 0;
  - state = RUN;
  - wait counter = 0.
- Reset taken in MEMWAIT returns to RUN the next edge. The pending access is abandoned.
- FSM states: RUN, MEMWAIT. The state is registered. Stall and flush outputs are combinational (Mealy) from the state and inputs.
- Priority, highest first: memory wait, branch flush, load-use.
- Memory wait:
  - Active when (RUN and mem_access and not mem_ready) or (MEMWAIT and not mem_ready and count < MEM_TIMEOUT-1).
  - While active: pc_stall, if_id_stall, id_exe_stall and exe_mem_stall are 1; mem_wb_bubble = 1; all flushes are 0.
  - RUN to MEMWAIT on the same condition; count is cleared to 0.
  - In MEMWAIT, count increments every cycle.
  - MEMWAIT with mem_ready: all stalls are 0 that cycle; next state is RUN.
  - MEMWAIT with count = MEM_TIMEOUT-1 and not mem_ready: stalls are released, err_timeout is set (sticky until reset), next state is RUN.
  - A MEMWAIT episode therefore lasts at most MEM_TIMEOUT stalled cycles.
- Branch flush (RUN, no memory wait):
  - exe_branch_taken = 1 gives if_id_flush = 1 and id_exe_flush = 1 for that cycle; no stalls.
  - A load-use condition in the same cycle is ignored, because the ID instruction is wrong-path.
- Load-use (RUN, no memory wait, no branch):
  - Condition: exe_memtoreg and exe_regwr and exe_rw != 0 and ((id_uses_rs and id_rs == exe_rw) or (id_uses_rt and id_rt == exe_rw)).
  - Response: pc_stall = 1, if_id_stall = 1, id_exe_flush = 1 for exactly one cycle.
- Forwarding (registered, aligned with ID/EXE):
  - The ID instruction is compared against destinations that will be one stage further on the next edge.
  - next_fwd_a = 01 if exe_regwr, exe_rw != 0, exe_rw == id_rs and not exe_memtoreg.
  - Otherwise next_fwd_a = 10 if mem_regwr, mem_rw != 0 and mem_rw == id_rs.
  - Otherwise next_fwd_a = 00.
  - next_fwd_b uses the same rules with id_rt.
  - Update rules: the fwd registers update when id_exe_stall = 0. They load 00 when id_exe_flush = 1. They hold when id_exe_stall = 1.
- Register $0 never triggers a hazard or a forward.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined: adds output ports ld_stall_cnt (32), br_flush_cnt (32) and mem_wait_cnt (32).
  - Each counter increments on its event cycle and is cleared by reset.
  - Each counter saturates at 32'hFFFFFFFF.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encoding (RUN = 1'b0, MEMWAIT = 1'b1);
  - forward-select constants FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10;
  - register-index width 5.
- One natural sub-module: fwd_select_unit.
  - Combinational comparison of one source register against the EXE and MEM destinations.
  - Instantiated twice, for rs and rt. Its registering stays in the parent.

Test Plan:
- Load-use: EXE = lw $5 (exe_memtoreg = 1, exe_regwr = 1, exe_rw = 5), ID id_rs = 5 with id_uses_rs = 1. Required: pc_stall = 1, if_id_stall = 1, id_exe_flush = 1 for one cycle. The next cycle, with mem_rw = 5, stalls are 0 and fwd_a registers 10.
- ALU forward: EXE add $3 (exe_regwr = 1, exe_rw = 3, exe_memtoreg = 0), ID id_rt = 3 with id_uses_rt = 1. Required: no stall; fwd_b = 01 after the edge. With exe_rw = 0 instead, fwd_b = 00.
- Branch vs load-use together: exe_branch_taken = 1 while the load-use condition is true. Required: if_id_flush = 1 and id_exe_flush = 1; pc_stall = 0; fwd registers are 00 after the edge.
- Memory wait: mem_access = 1 and mem_ready held 0 for 3 cycles, then 1. Required: all stalls = 1 and mem_wb_bubble = 1 for 3 cycles; 0 in the ready cycle; state returns to RUN; err_timeout = 0.
- Timeout: MEM_TIMEOUT = 4, mem_ready held 0. Required: stalls = 1 for exactly 4 cycles, then 0; err_timeout = 1 and remains 1 until reset.
- Reset mid-wait: reset = 0 during MEMWAIT. Required: all outputs 0 at the next edge, state RUN, and err_timeout cleared.
